// File: rtl/gray2rgb_byte_tx.sv
// Expands each single-channel gray pixel into three byte-serial beats (R, G, B).
// last_o marks the B beat of the final pixel in each line. Define GRAY2RGB_FALSE_COLOR_EN for false-colour channels.
module gray2rgb_byte_tx #(
  parameter int unsigned WIDTH_P  = 8,
  parameter int unsigned LINE_W_P = 640
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH_P-1:0] gray_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH_P-1:0] data_o,
  output logic               last_o
);

  localparam int unsigned CntW = (LINE_W_P > 1) ? $clog2(LINE_W_P) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(LINE_W_P - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSendR,
    StSendG,
    StSendB
  } state_e;

  state_e              r_state;
  logic                r_valid;
  logic                r_last;
  logic [WIDTH_P-1:0]  r_data;
  logic [CntW-1:0]     r_cnt;

  logic                w_ready;
  logic                w_in_xfer;
  logic                w_cnt_wrap;
  logic [WIDTH_P-1:0]  w_chan_g;
  logic [WIDTH_P-1:0]  w_chan_b;

  // Accept a new pixel while the last beat of the current one leaves.
  assign w_ready    = (r_state == StIdle) || ((r_state == StSendB) && ready_i);
  assign w_in_xfer  = valid_i && w_ready;
  assign w_cnt_wrap = (r_cnt == CntMax);

`ifdef GRAY2RGB_FALSE_COLOR_EN
  logic [WIDTH_P-1:0] r_chan_g;
  logic [WIDTH_P-1:0] r_chan_b;
  logic [WIDTH_P-1:0] w_gray_inv;

  assign w_gray_inv = ~gray_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_chan_g <= '0;
      r_chan_b <= '0;
    end else if (w_in_xfer) begin
      r_chan_g <= gray_i >> 1;
      r_chan_b <= w_gray_inv >> 2;
    end
  end

  assign w_chan_g = r_chan_g;
  assign w_chan_b = r_chan_b;
`else
  logic [WIDTH_P-1:0] r_pix;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pix <= '0;
    end else if (w_in_xfer) begin
      r_pix <= gray_i;
    end
  end

  assign w_chan_g = r_pix;
  assign w_chan_b = r_pix;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_in_xfer) begin
            r_state <= StSendR;
            r_valid <= 1'b1;
            r_data  <= gray_i;
            r_last  <= 1'b0;
          end
        end
        StSendR: begin
          if (ready_i) begin
            r_state <= StSendG;
            r_data  <= w_chan_g;
          end
        end
        StSendG: begin
          if (ready_i) begin
            r_state <= StSendB;
            r_data  <= w_chan_b;
            r_last  <= w_cnt_wrap;
          end
        end
        StSendB: begin
          if (ready_i) begin
            r_cnt  <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
            r_last <= 1'b0;
            if (w_in_xfer) begin
              r_state <= StSendR;
              r_data  <= gray_i;
            end else begin
              r_state <= StIdle;
              r_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = w_ready;
  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign last_o  = r_last;

endmodule

// File: doc/gray2rgb_byte_tx.md
Name: gray2rgb_byte_tx

Overview:
Output-side converter for the Sobel pipeline. It takes a valid/ready stream of single-channel gray or edge-magnitude pixels and expands each pixel into three byte-serial channel beats in R, G, B order. The result is a byte stream for the display/UART egress path.
A per-line pixel counter marks the final byte of each image line with last_o.

Parameters:
WIDTH_P, 8, bit width of the gray input and of each output channel beat
LINE_W_P, 640, pixels per image line; must be >= 1; last_o period in pixels

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
valid_i  input  1  upstream gray pixel valid
ready_o  output  1  block can accept a gray pixel this cycle
gray_i  input  WIDTH_P  gray pixel value
valid_o  output  1  data_o holds a valid channel beat
ready_i  input  1  downstream accepts the beat
data_o  output  WIDTH_P  current channel byte (R, then G, then B)
last_o  output  1  high with the B beat of the last pixel in a line

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high, sampled on the rising edge of clk_i.
- Handshakes:
  - Input transfer: valid_i && ready_o.
  - Output transfer: valid_o && ready_i.
- State machine has four states: IDLE, SEND_R, SEND_G, SEND_B.
- Reset values:
  - state = IDLE, valid_o = 0, data_o = 0, last_o = 0.
  - Pixel holding register = 0, line counter = 0.
- ready_o = (state == IDLE) || (state == SEND_B && ready_i). This is combinational from ready_i, giving back-to-back acceptance with no bubble.
- Transitions:
  - IDLE: on input transfer, capture gray_i and go to SEND_R. Otherwise stay.
  - SEND_R: on output transfer, go to SEND_G. Otherwise hold.
  - SEND_G: on output transfer, go to SEND_B. Otherwise hold.
  - SEND_B, output transfer with input transfer in the same cycle: capture the new pixel and go to SEND_R.
  - SEND_B, output transfer without input transfer: go to IDLE.
  - SEND_B, no output transfer: hold; ready_o = 0.
- valid_o = 1 in every SEND_* state and 0 in IDLE.
- data_o and last_o are registered and stay stable while valid_o && !ready_i. No change is permitted under backpressure.
- Latency: a pixel accepted on edge N presents its R beat at cycle N+1.
- Throughput: 3 cycles per pixel with ready_i held high continuously.
- Channel mapping (default build): R = G = B = captured gray value, unmodified, with no rounding and no width growth.
- Line counter:
  - Width is $clog2(LINE_W_P), minimum 1 bit.
  - Increments on the output transfer of each B beat.
  - last_o = 1 during SEND_B when counter == LINE_W_P-1.
  - On that B transfer the counter wraps to 0.
  - LINE_W_P = 1: last_o is high on every B beat.
- valid_i while ready_o = 0: the input is not consumed, and upstream must hold its data.
- Reset mid-pixel: any remaining beats are dropped, and the next pixel starts at R with counter = 0. Reset has priority over all simultaneous handshakes.
- No combinational path from valid_i or gray_i to any output.

Optional Feature:
GRAY2RGB_FALSE_COLOR_EN
- Defined: channel values are computed at capture from the gray value g:
  - R = g
  - G = g >> 1
  - B = (~g) >> 2
  - all WIDTH_P-bit, zero-filled on the right shift.
  - Purpose: warm tint for strong edges, blue tint for flat areas.
  - Timing, handshake and last_o are identical to the default build.
- Undefined: R = G = B = g. No additional logic is synthesised.

Test Plan:
- Reset then single pixel (WIDTH_P=8), gray_i=0x5A, ready_i=1 -> beats 0x5A, 0x5A, 0x5A on cycles 1-3, then IDLE with valid_o=0 and last_o=0.
- Streaming with valid_i=1, ready_i=1, pixels 0x10, 0x20, 0x30 -> 9 consecutive valid beats with no gaps. ready_o is high exactly in the cycles where a B beat is transferred.
- Backpressure: ready_i=0 for 4 cycles during the G beat of pixel 0xC3 -> data_o holds 0xC3 and valid_o holds 1. ready_o=0 throughout. Sequence resumes G, then B, with no loss or duplication.
- Line marking with LINE_W_P=4, 9 pixels streamed -> last_o high only on the B beats of pixels 3 and 7 (0-based). Counter wraps, and pixel 8 has last_o=0.
- rst_i asserted on the G beat of a pixel, with valid_i high in the same cycle -> next cycle valid_o=0, data_o=0, state IDLE, no input consumed. Next pixel starts at R, and last_o timing restarts from count 0.
- With GRAY2RGB_FALSE_COLOR_EN defined:
  - gray 0x80 -> beats 0x80, 0x40, 0x1F.
  - gray 0xFF -> beats 0xFF, 0x7F, 0x00.
